id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS-style core.
- Captures decoded control, register-file read data, the sign-extended immediate and register specifiers from ID, and presents them to EX on the following cycle.
- Integrates load-use hazard detection: emits hazard_o to freeze PC and IF/ID, and inserts a bubble into EX.
- Supports an external pipeline freeze (hold_i) and a branch/jump squash (flush_i).
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register specifier width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge only.
- rst_i  in  1  synchronous, active-high reset.
- hold_i  in  1  freeze: stage retains its contents.
- flush_i  in  1  squash: next contents become a bubble.
- id_valid_i  in  1  ID holds a real instruction.
- WB_i  in  2  [1]=RegWrite, [0]=MemtoReg.
- MEM_i  in  2  [1]=MemWrite, [0]=MemRead.
- EX_i  in  4  [3]=RegDst, [2]=ALUSrc, [1:0]=ALUOp.
- RsData_i, RtData_i, Imm_i  in  DATA_W  operands.
- Rs_i, Rt_i, Rd_i  in  REG_AW  register specifiers.
- WB_o  out  2
- MEM_o  out  2
- EX_o  out  4
- RsData_o, RtData_o, Imm_o  out  DATA_W
- Rs_o, Rt_o, Rd_o  out  REG_AW
- valid_o  out  1  EX holds a real instruction.
- hazard_o  out  1  combinational load-use stall request to PC/IF_ID.
- bubble_cnt_o  out  CNT_W  bubbles inserted due to load-use.

Behaviour:
- Reset: every registered output is 0, including valid_o and bubble_cnt_o. hazard_o is therefore 0 in the cycle after reset.
- Latency: 1 cycle, ID inputs to outputs. Single posedge register stage; no negedge logic.
- Hazard detect (combinational): detect = valid_o & MEM_o[0] & (Rt_o != 0) & id_valid_i & ((Rt_o == Rs_i) | (Rt_o == Rt_i)).
- hazard_o = detect & ~flush_i.
- Per-cycle update, in priority order:
  1. rst_i: clear all outputs.
  2. flush_i: bubble. WB_o, MEM_o, EX_o and valid_o go to 0; data and specifier fields load normally (don't-care); counter unchanged.
  3. hold_i: all outputs retain their values, counter included.
  4. detect: bubble as in flush, and bubble_cnt_o increments.
  5. Otherwise: load all inputs; valid_o <= id_valid_i. If id_valid_i=0, control fields are forced to 0.
- Counter saturates at all-ones and never wraps.
- During a load-use bubble the load has moved on to MEM, so detect deasserts the next cycle: exactly one bubble per load-use pair.
- hold_i with a pending detect: hazard_o stays high, no bubble is inserted and the counter does not move; the bubble occurs on the first cycle with hold_i low.
- flush_i together with detect: flush wins, hazard_o=0, counter unchanged.
- rst_i asserted mid-stream: clears on that edge regardless of hold_i or flush_i.

Decomposition:
- Shared package (cpu_pkg):
  - Field index constants: WB_REGWRITE=1, WB_MEMTOREG=0, MEM_WRITE=1, MEM_READ=0, EX_REGDST=3, EX_ALUSRC=2.
  - ALUOp encodings.
  - DATA_W / REG_AW defaults.
- One sub-module, load_use_detect: the purely combinational detect equation, reused later by the forwarding unit's bench.
- Register, priority mux and counter stay in id_ex_stage.

Test Plan:
- Reset: drive nonzero inputs with rst_i=1 for 2 cycles -> all outputs 0, valid_o=0, bubble_cnt_o=0.
- Pass-through: id_valid_i=1, WB_i=2'b10, MEM_i=0, EX_i=4'b1010, RsData_i=32'h1234_5678, Rs_i=5, Rt_i=6, Rd_i=7 -> identical values on outputs one cycle later, valid_o=1.
- Load-use: the "lw $8" instruction is in EX (MEM_o=2'b01, Rt_o=8, valid_o=1) and ID has Rs_i=8 -> hazard_o=1 that cycle. Next cycle WB_o/MEM_o/EX_o=0, valid_o=0, bubble_cnt_o=1, hazard_o=0. Rt_o=0 with the same stimulus -> hazard_o=0.
- Flush vs hazard: load-use condition plus flush_i=1 -> hazard_o=0, bubble inserted, bubble_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing inputs -> outputs frozen. Pending detect keeps hazard_o=1, and the bubble plus counter increment occur on the first cycle after hold_i drops.
- Saturation: preload the counter to 16'hFFFE, then 3 load-use events -> bubble_cnt_o reads FFFF, FFFF, FFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: control-field bit positions,
// ALU operation encodings and default datapath widths.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  localparam int unsigned WB_W  = 2;
  localparam int unsigned MEM_W = 2;
  localparam int unsigned EX_W  = 4;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned MEM_WRITE   = 1;
  localparam int unsigned MEM_READ    = 0;
  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUSRC   = 2;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX has not yet fetched from memory.
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              detect
);

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign detect = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, freeze, squash
// and a saturating count of load-use bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        MEM_i,
  input  logic [3:0]        EX_i,
  input  logic [DATA_W-1:0] RsData_i,
  input  logic [DATA_W-1:0] RtData_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [REG_AW-1:0] Rs_i,
  input  logic [REG_AW-1:0] Rt_i,
  input  logic [REG_AW-1:0] Rd_i,
  output logic [1:0]        WB_o,
  output logic [1:0]        MEM_o,
  output logic [3:0]        EX_o,
  output logic [DATA_W-1:0] RsData_o,
  output logic [DATA_W-1:0] RtData_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [REG_AW-1:0] Rs_o,
  output logic [REG_AW-1:0] Rt_o,
  output logic [REG_AW-1:0] Rd_o,
  output logic              valid_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic detect;
  logic cnt_full;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_detect (
    .ex_valid   (valid_o),
    .ex_mem_read(MEM_o[MEM_READ]),
    .ex_rt      (Rt_o),
    .id_valid   (id_valid_i),
    .id_rs      (Rs_i),
    .id_rt      (Rt_i),
    .detect     (detect)
  );

  // A squash already removes the dependent instruction, so no stall is needed.
  assign hazard_o = detect & ~flush_i;
  assign cnt_full = &bubble_cnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      WB_o         <= '0;
      MEM_o        <= '0;
      EX_o         <= '0;
      RsData_o     <= '0;
      RtData_o     <= '0;
      Imm_o        <= '0;
      Rs_o         <= '0;
      Rt_o         <= '0;
      Rd_o         <= '0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (flush_i) begin
      WB_o     <= '0;
      MEM_o    <= '0;
      EX_o     <= '0;
      valid_o  <= 1'b0;
      RsData_o <= RsData_i;
      RtData_o <= RtData_i;
      Imm_o    <= Imm_i;
      Rs_o     <= Rs_i;
      Rt_o     <= Rt_i;
      Rd_o     <= Rd_i;
    end else if (!hold_i) begin
      RsData_o <= RsData_i;
      RtData_o <= RtData_i;
      Imm_o    <= Imm_i;
      Rs_o     <= Rs_i;
      Rt_o     <= Rt_i;
      Rd_o     <= Rd_i;
      if (detect) begin
        WB_o    <= '0;
        MEM_o   <= '0;
        EX_o    <= '0;
        valid_o <= 1'b0;
        if (!cnt_full) begin
          bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
      end else begin
        valid_o <= id_valid_i;
        WB_o    <= id_valid_i ? WB_i  : '0;
        MEM_o   <= id_valid_i ? MEM_i : '0;
        EX_o    <= id_valid_i ? EX_i  : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 3-bit counter
// shares the stimulus so counter saturation is reachable in few cycles.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_i, hold_i, flush_i, id_valid_i;
  logic [1:0]  WB_i, MEM_i;
  logic [3:0]  EX_i;
  logic [31:0] RsData_i, RtData_i, Imm_i;
  logic [4:0]  Rs_i, Rt_i, Rd_i;

  logic [1:0]  WB_o, MEM_o;
  logic [3:0]  EX_o;
  logic [31:0] RsData_o, RtData_o, Imm_o;
  logic [4:0]  Rs_o, Rt_o, Rd_o;
  logic        valid_o, hazard_o;
  logic [15:0] bubble_cnt_o;

  logic [1:0]  s_WB_o, s_MEM_o;
  logic [3:0]  s_EX_o;
  logic [31:0] s_RsData_o, s_RtData_o, s_Imm_o;
  logic [4:0]  s_Rs_o, s_Rt_o, s_Rd_o;
  logic        s_valid_o, s_hazard_o;
  logic [2:0]  s_bubble_cnt_o;

  int unsigned passes = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i),
    .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
    .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
    .WB_o(WB_o), .MEM_o(MEM_o), .EX_o(EX_o),
    .RsData_o(RsData_o), .RtData_o(RtData_o), .Imm_o(Imm_o),
    .Rs_o(Rs_o), .Rt_o(Rt_o), .Rd_o(Rd_o),
    .valid_o(valid_o), .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) dut_small (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i),
    .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
    .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
    .WB_o(s_WB_o), .MEM_o(s_MEM_o), .EX_o(s_EX_o),
    .RsData_o(s_RsData_o), .RtData_o(s_RtData_o), .Imm_o(s_Imm_o),
    .Rs_o(s_Rs_o), .Rt_o(s_Rt_o), .Rd_o(s_Rd_o),
    .valid_o(s_valid_o), .hazard_o(s_hazard_o), .bubble_cnt_o(s_bubble_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                       input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm);
    id_valid_i = v; WB_i = wb; MEM_i = mem; EX_i = ex;
    Rs_i = rs; Rt_i = rt; Rd_i = rd;
    RsData_i = rsd; RtData_i = rtd; Imm_i = imm;
  endtask

  // lw $rt, 4($29)
  task automatic drive_lw(input logic [4:0] rt);
    drive(1'b1, 2'b11, 2'b01, 4'b0100, 5'd29, rt, 5'd0, 32'h1000_0000, 32'h0, 32'h4);
  endtask

  // add $9, $rs, $rt
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 2'b10, 2'b00, 4'b1010, rs, rt, 5'd9, 32'h11, 32'h22, 32'h0);
  endtask

  initial begin
    hold_i = 1'b0; flush_i = 1'b0;
    // Reset with busy inputs
    rst_i = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 4'b1111, 5'd8, 5'd8, 5'd8, 32'hdead_beef, 32'hcafe_f00d, 32'h5a5a_5a5a);
    tick(); tick();
    chk("rst_wb", 32'(WB_o), 32'h0);
    chk("rst_mem", 32'(MEM_o), 32'h0);
    chk("rst_ex", 32'(EX_o), 32'h0);
    chk("rst_rsdata", RsData_o, 32'h0);
    chk("rst_imm", Imm_o, 32'h0);
    chk("rst_rt", 32'(Rt_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_cnt", 32'(bubble_cnt_o), 32'h0);
    chk("rst_hazard", 32'(hazard_o), 32'h0);
    rst_i = 1'b0;

    // Pass-through of a valid instruction
    drive(1'b1, 2'b10, 2'b00, 4'b1010, 5'd5, 5'd6, 5'd7, 32'h1234_5678, 32'h9abc_def0, 32'hffff_fff4);
    tick();
    chk("pt_wb", 32'(WB_o), 32'h2);
    chk("pt_mem", 32'(MEM_o), 32'h0);
    chk("pt_ex", 32'(EX_o), 32'ha);
    chk("pt_rsdata", RsData_o, 32'h1234_5678);
    chk("pt_rtdata", RtData_o, 32'h9abc_def0);
    chk("pt_imm", Imm_o, 32'hffff_fff4);
    chk("pt_rs", 32'(Rs_o), 32'd5);
    chk("pt_rt", 32'(Rt_o), 32'd6);
    chk("pt_rd", 32'(Rd_o), 32'd7);
    chk("pt_valid", 32'(valid_o), 32'h1);

    // Invalid ID slot: control forced to zero, data still loads
    drive(1'b0, 2'b11, 2'b01, 4'b1111, 5'd1, 5'd2, 5'd3, 32'haaaa_aaaa, 32'h0, 32'h0);
    tick();
    chk("inv_wb", 32'(WB_o), 32'h0);
    chk("inv_mem", 32'(MEM_o), 32'h0);
    chk("inv_ex", 32'(EX_o), 32'h0);
    chk("inv_valid", 32'(valid_o), 32'h0);
    chk("inv_rsdata", RsData_o, 32'haaaa_aaaa);
    chk("inv_rs", 32'(Rs_o), 32'd1);

    // Load-use: lw $8 in EX, add reading $8 in ID
    drive_lw(5'd8);
    tick();
    chk("lu_mem", 32'(MEM_o), 32'h1);
    chk("lu_rt", 32'(Rt_o), 32'd8);
    drive_add(5'd8, 5'd10);
    #1;
    chk("lu_hazard", 32'(hazard_o), 32'h1);
    tick();
    chk("lu_bub_wb", 32'(WB_o), 32'h0);
    chk("lu_bub_mem", 32'(MEM_o), 32'h0);
    chk("lu_bub_ex", 32'(EX_o), 32'h0);
    chk("lu_bub_valid", 32'(valid_o), 32'h0);
    chk("lu_bub_cnt", 32'(bubble_cnt_o), 32'd1);
    chk("lu_bub_hazard", 32'(hazard_o), 32'h0);
    tick();
    chk("lu_after_valid", 32'(valid_o), 32'h1);
    chk("lu_after_wb", 32'(WB_o), 32'h2);
    chk("lu_after_rs", 32'(Rs_o), 32'd8);
    chk("lu_after_cnt", 32'(bubble_cnt_o), 32'd1);

    // Load to $0 never stalls
    drive_lw(5'd0);
    tick();
    drive_add(5'd0, 5'd0);
    #1;
    chk("r0_hazard", 32'(hazard_o), 32'h0);
    tick();
    chk("r0_valid", 32'(valid_o), 32'h1);
    chk("r0_cnt", 32'(bubble_cnt_o), 32'd1);

    // Flush beats hazard
    drive_lw(5'd8);
    tick();
    drive_add(5'd8, 5'd3);
    flush_i = 1'b1;
    #1;
    chk("fl_hazard", 32'(hazard_o), 32'h0);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", 32'(valid_o), 32'h0);
    chk("fl_mem", 32'(MEM_o), 32'h0);
    chk("fl_wb", 32'(WB_o), 32'h0);
    chk("fl_cnt", 32'(bubble_cnt_o), 32'd1);
    chk("fl_rs", 32'(Rs_o), 32'd8);

    // Hold with a pending load-use
    drive_lw(5'd8);
    tick();
    drive_add(5'd3, 5'd8);
    hold_i = 1'b1;
    #1;
    chk("hd_hazard0", 32'(hazard_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      RsData_i = 32'h100 + 32'(i);
      Rd_i = 5'(20 + i);
      tick();
      chk("hd_mem", 32'(MEM_o), 32'h1);
      chk("hd_rsdata", RsData_o, 32'h1000_0000);
      chk("hd_rd", 32'(Rd_o), 32'd0);
      chk("hd_valid", 32'(valid_o), 32'h1);
      chk("hd_cnt", 32'(bubble_cnt_o), 32'd1);
      chk("hd_hazard", 32'(hazard_o), 32'h1);
    end
    hold_i = 1'b0;
    tick();
    chk("hd_bub_valid", 32'(valid_o), 32'h0);
    chk("hd_bub_mem", 32'(MEM_o), 32'h0);
    chk("hd_bub_cnt", 32'(bubble_cnt_o), 32'd2);
    chk("hd_bub_hazard", 32'(hazard_o), 32'h0);

    // Reset beats hold
    drive_lw(5'd8);
    tick();
    hold_i = 1'b1;
    rst_i = 1'b1;
    tick();
    chk("mr_cnt", 32'(bubble_cnt_o), 32'd0);
    chk("mr_valid", 32'(valid_o), 32'h0);
    chk("mr_rt", 32'(Rt_o), 32'd0);
    chk("mr_small_cnt", 32'(s_bubble_cnt_o), 32'd0);
    hold_i = 1'b0;
    rst_i = 1'b0;

    // Saturation: small counter brought to all-ones minus one, then three more events
    for (int i = 0; i < 6; i++) begin
      drive_lw(5'd8);
      tick();
      drive_add(5'd8, 5'd10);
      tick();
    end
    chk("sat_pre_small", 32'(s_bubble_cnt_o), 32'd6);
    chk("sat_pre_main", 32'(bubble_cnt_o), 32'd6);
    for (int k = 0; k < 3; k++) begin
      drive_lw(5'd8);
      tick();
      drive_add(5'd8, 5'd10);
      tick();
      chk("sat_small", 32'(s_bubble_cnt_o), 32'd7);
      chk("sat_main", 32'(bubble_cnt_o), 32'(7 + k));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
